exec_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller for the 8-bit, four-register (r0–r3) CPU core.
- Each instruction is latched from the input pins, then the move/branch unit and register file are enabled for exactly one execute cycle.
- The block owns the program counter and reacts to the four move/branch strobes: branch, memory write, memory read and output toggle.
- It also runs the external memory request handshake and drives the output-pin mux between the PC and r3.

---
 rtl/exec_sequencer_pkg.sv | 20 ++
 rtl/exec_sequencer_mem_handshake_timer.sv | 84 ++++++++
 rtl/exec_sequencer.sv | 131 +++++++++++++
 tb/tb_exec_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding, widths
// and the strobe ordering used by the move/branch decode.
package exec_sequencer_pkg;

  localparam int unsigned PKG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2
  } state_e;

  // Bit positions in the packed strobe vector, matching the 2-to-4 decode.
  localparam int unsigned STB_BRANCH = 0;
  localparam int unsigned STB_MEM_WR = 1;
  localparam int unsigned STB_MEM_RD = 2;
  localparam int unsigned STB_TOGGLE = 3;
  localparam int unsigned STB_W      = 4;

endpackage

// File: rtl/exec_sequencer_mem_handshake_timer.sv
// External memory request handshake: holds mem_req/mem_we, counts wait cycles,
// aborts on timeout with a sticky error and issues completion/abort pulses.
module exec_sequencer_mem_handshake_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_we,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_mem_req,
  output logic o_mem_we,
  output logic o_mem_err,
  output logic o_rd_load,
  output logic o_done
);

  logic            r_req;
  logic            r_we;
  logic            r_err;
  logic            r_rd_load;
  logic [TO_W-1:0] r_count;

  logic            w_req_d;
  logic            w_we_d;
  logic            w_err_d;
  logic            w_rd_load_d;
  logic [TO_W-1:0] w_count_d;
  logic            w_done;

  always_comb begin
    w_req_d     = r_req;
    w_we_d      = r_we;
    w_err_d     = r_err;
    w_rd_load_d = 1'b0;
    w_count_d   = r_count;
    w_done      = 1'b0;
    if (i_start) begin
      w_req_d   = 1'b1;
      w_we_d    = i_we;
      w_count_d = '0;
    end else if (i_active) begin
      // Completion is checked first so a late ready still wins over the abort.
      if (i_mem_ready) begin
        w_req_d     = 1'b0;
        w_we_d      = 1'b0;
        w_rd_load_d = ~r_we;
        w_done      = 1'b1;
      end else if (r_count == TO_W'(MEM_TIMEOUT)) begin
        w_req_d = 1'b0;
        w_we_d  = 1'b0;
        w_err_d = 1'b1;
        w_done  = 1'b1;
      end else begin
        w_count_d = r_count + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_rd_load <= 1'b0;
      r_count   <= '0;
    end else begin
      r_req     <= w_req_d;
      r_we      <= w_we_d;
      r_err     <= w_err_d;
      r_rd_load <= w_rd_load_d;
      r_count   <= w_count_d;
    end
  end

  assign o_mem_req = r_req;
  assign o_mem_we  = r_we;
  assign o_mem_err = r_err;
  assign o_rd_load = r_rd_load;
  assign o_done    = w_done;

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/execute controller: owns the PC, latches instructions, sequences the
// one-cycle execute window and the memory handshake, and drives the pin mux.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W      = PKG_DATA_W,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              bcf,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              toggle_out,
  input  logic [DATA_W-1:0] r3_val,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              exec_en,
  output logic              reg_we,
  output logic              rd_load,
  output logic              mem_req,
  output logic              mem_we,
  output logic              out_sel,
  output logic [DATA_W-1:0] io_out,
  output logic              mem_err
);

  state_e            r_state;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_out_sel;

  state_e            w_state_d;
  logic [DATA_W-1:0] w_pc_d;
  logic [DATA_W-1:0] w_instr_d;
  logic              w_out_sel_d;
  logic              w_exec_en;
  logic              w_reg_we;
  logic              w_start;
  logic              w_start_we;
  logic              w_mem_done;
  logic [STB_W-1:0]  w_strobes;

  assign w_strobes[STB_BRANCH] = bcf;
  assign w_strobes[STB_MEM_WR] = mem_write;
  assign w_strobes[STB_MEM_RD] = mem_read;
  assign w_strobes[STB_TOGGLE] = toggle_out;

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_instr_d   = r_instr;
    w_out_sel_d = r_out_sel;
    w_exec_en   = 1'b0;
    w_reg_we    = 1'b0;
    w_start     = 1'b0;
    w_start_we  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_instr_d = instr_in;
        w_state_d = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec_en = 1'b1;
        w_state_d = ST_FETCH;
        if (w_strobes[STB_BRANCH]) begin
          w_pc_d = r_pc + r3_val;
        end else if (w_strobes[STB_MEM_WR] || w_strobes[STB_MEM_RD]) begin
          w_start    = 1'b1;
          w_start_we = w_strobes[STB_MEM_WR];
          w_state_d  = ST_MEM;
        end else if (w_strobes[STB_TOGGLE]) begin
          w_out_sel_d = ~r_out_sel;
          w_pc_d      = r_pc + DATA_W'(1);
        end else begin
          w_reg_we = 1'b1;
          w_pc_d   = r_pc + DATA_W'(1);
        end
      end
      ST_MEM: begin
        if (w_mem_done) begin
          w_pc_d    = r_pc + DATA_W'(1);
          w_state_d = ST_FETCH;
        end
      end
      default: w_state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_instr   <= '0;
      r_out_sel <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_instr   <= w_instr_d;
      r_out_sel <= w_out_sel_d;
    end
  end

  exec_sequencer_mem_handshake_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_mem_timer (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_we       (w_start_we),
    .i_active   (r_state == ST_MEM),
    .i_mem_ready(mem_ready),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_err  (mem_err),
    .o_rd_load  (rd_load),
    .o_done     (w_mem_done)
  );

  assign pc      = r_pc;
  assign instr   = r_instr;
  assign exec_en = w_exec_en;
  assign reg_we  = w_reg_we;
  assign out_sel = r_out_sel;
  assign io_out  = r_out_sel ? r3_val : r_pc;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: directed instruction table, reset-during-MEM sequence
// and randomized instruction stream against an instruction-level model.
module tb_exec_sequencer;

  localparam int MEM_TIMEOUT = 15;

  // Instruction kinds driven on the strobes during EXEC.
  localparam int K_NONE = 0, K_BR = 1, K_WR = 2, K_RD = 3, K_TOG = 4;
  localparam int K_BR_WR = 5, K_RD_TOG = 6, K_WR_RD = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr_in;
  logic       bcf, mem_write, mem_read, toggle_out;
  logic [7:0] r3_val;
  logic       mem_ready;
  logic [7:0] pc, instr, io_out;
  logic       exec_en, reg_we, rd_load, mem_req, mem_we, out_sel, mem_err;

  exec_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .instr_in  (instr_in),
    .bcf       (bcf),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .toggle_out(toggle_out),
    .r3_val    (r3_val),
    .mem_ready (mem_ready),
    .pc        (pc),
    .instr     (instr),
    .exec_en   (exec_en),
    .reg_we    (reg_we),
    .rd_load   (rd_load),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .out_sel   (out_sel),
    .io_out    (io_out),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model state.
  logic [7:0] m_pc;
  logic       m_sel;
  logic       m_err;
  logic       m_rdl;

  typedef struct {
    int         kind;
    logic [7:0] r3;
    int         wt;     // MEM cycle index at which mem_ready is given, -1 never
    logic [7:0] pc;     // expected pc after the instruction
    logic       sel;
    logic       err;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_common(input string name, input logic e_exec, input logic e_rwe,
                            input logic e_req, input logic e_rdl);
    check({name, "_exec_en"}, 32'(exec_en), 32'(e_exec));
    check({name, "_reg_we"}, 32'(reg_we), 32'(e_rwe));
    check({name, "_mem_req"}, 32'(mem_req), 32'(e_req));
    check({name, "_rd_load"}, 32'(rd_load), 32'(e_rdl));
    check({name, "_pc"}, 32'(pc), 32'(m_pc));
    check({name, "_out_sel"}, 32'(out_sel), 32'(m_sel));
    check({name, "_io_out"}, 32'(io_out), 32'(m_sel ? r3_val : m_pc));
    check({name, "_mem_err"}, 32'(mem_err), 32'(m_err));
  endtask

  task automatic clear_strobes();
    bcf = 1'b0; mem_write = 1'b0; mem_read = 1'b0; toggle_out = 1'b0;
  endtask

  task automatic do_instr(input int kind, input logic [7:0] r3, input int wt,
                          input logic [7:0] ib);
    logic rdy;
    logic is_wr;
    int   n;
    // FETCH
    @(negedge clk);
    instr_in = ib; r3_val = r3; mem_ready = 1'b0;
    clear_strobes();
    #1;
    chk_common("fetch", 1'b0, 1'b0, 1'b0, m_rdl);
    @(posedge clk);
    m_rdl = 1'b0;
    // EXEC
    @(negedge clk);
    bcf        = (kind == K_BR) || (kind == K_BR_WR);
    mem_write  = (kind == K_WR) || (kind == K_BR_WR) || (kind == K_WR_RD);
    mem_read   = (kind == K_RD) || (kind == K_RD_TOG) || (kind == K_WR_RD);
    toggle_out = (kind == K_TOG) || (kind == K_RD_TOG);
    instr_in   = ~ib;
    #1;
    check("exec_instr", 32'(instr), 32'(ib));
    chk_common("exec", 1'b1, !(bcf || mem_write || mem_read || toggle_out), 1'b0, 1'b0);
    @(posedge clk);
    if (bcf) begin
      m_pc = m_pc + r3;
    end else if (mem_write || mem_read) begin
      is_wr = mem_write;
      n = 0;
      while (1) begin
        @(negedge clk);
        clear_strobes();
        rdy = (n == wt);
        mem_ready = rdy;
        #1;
        chk_common("mem", 1'b0, 1'b0, 1'b1, 1'b0);
        check("mem_we", 32'(mem_we), 32'(is_wr));
        @(posedge clk);
        if (rdy) begin
          m_rdl = !is_wr;
          break;
        end
        if (n == MEM_TIMEOUT) begin
          m_err = 1'b1;
          break;
        end
        n++;
      end
      m_pc = m_pc + 8'd1;
    end else begin
      if (toggle_out) m_sel = ~m_sel;
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_strobes();
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_pc = 8'h00; m_sel = 1'b0; m_err = 1'b0; m_rdl = 1'b0;
    chk_common("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_instr", 32'(instr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_in = 8'h00; r3_val = 8'h00; mem_ready = 1'b0;
    clear_strobes();
    m_pc = 8'h00; m_sel = 1'b0; m_err = 1'b0; m_rdl = 1'b0;

    tbl[0]  = '{K_NONE,   8'h00, -1, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{K_NONE,   8'h00, -1, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{K_NONE,   8'h00, -1, 8'h03, 1'b0, 1'b0};
    tbl[3]  = '{K_BR,     8'h0D, -1, 8'h10, 1'b0, 1'b0};
    tbl[4]  = '{K_BR,     8'hF5, -1, 8'h05, 1'b0, 1'b0};
    tbl[5]  = '{K_RD,     8'h00,  3, 8'h06, 1'b0, 1'b0};
    tbl[6]  = '{K_NONE,   8'h00, -1, 8'h07, 1'b0, 1'b0};
    tbl[7]  = '{K_TOG,    8'hAA, -1, 8'h08, 1'b1, 1'b0};
    tbl[8]  = '{K_NONE,   8'hAA, -1, 8'h09, 1'b1, 1'b0};
    tbl[9]  = '{K_TOG,    8'hAA, -1, 8'h0A, 1'b0, 1'b0};
    tbl[10] = '{K_RD,     8'h00, 15, 8'h0B, 1'b0, 1'b0};
    tbl[11] = '{K_NONE,   8'h00, -1, 8'h0C, 1'b0, 1'b0};
    tbl[12] = '{K_WR,     8'h00, -1, 8'h0D, 1'b0, 1'b1};
    tbl[13] = '{K_NONE,   8'h00, -1, 8'h0E, 1'b0, 1'b1};
    tbl[14] = '{K_BR,     8'h00, -1, 8'h0E, 1'b0, 1'b1};
    tbl[15] = '{K_BR_WR,  8'hF2, -1, 8'h00, 1'b0, 1'b1};
    tbl[16] = '{K_BR,     8'hFF, -1, 8'hFF, 1'b0, 1'b1};
    tbl[17] = '{K_NONE,   8'h00, -1, 8'h00, 1'b0, 1'b1};
    tbl[18] = '{K_RD_TOG, 8'h33,  0, 8'h01, 1'b0, 1'b1};
    tbl[19] = '{K_NONE,   8'h00, -1, 8'h02, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      do_instr(tbl[i].kind, tbl[i].r3, tbl[i].wt, 8'h40 + 8'(i));
      #1;
      check("tbl_pc", 32'(pc), 32'(tbl[i].pc));
      check("tbl_out_sel", 32'(out_sel), 32'(tbl[i].sel));
      check("tbl_mem_err", 32'(mem_err), 32'(tbl[i].err));
    end

    // Reset on the second MEM cycle of a write, with out_sel and mem_err set.
    do_instr(K_TOG, 8'h5A, -1, 8'h77);
    @(negedge clk);
    instr_in = 8'h99; clear_strobes();
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b1;
    #1;
    check("rstmem_exec_en", 32'(exec_en), 32'h1);
    @(posedge clk);
    @(negedge clk);
    clear_strobes();
    #1;
    check("rstmem_req1", 32'(mem_req), 32'h1);
    @(posedge clk);
    do_reset();
    check("rstmem_out_sel", 32'(out_sel), 32'h0);
    check("rstmem_mem_err", 32'(mem_err), 32'h0);

    // Overlap straight after reset: branch taken, no memory request.
    do_instr(K_BR_WR, 8'h21, -1, 8'h12);
    #1;
    check("ovl_pc", 32'(pc), 32'h21);
    check("ovl_mem_req", 32'(mem_req), 32'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      int k;
      int w;
      k = $urandom_range(0, 7);
      w = $urandom_range(0, 17);
      if (w > MEM_TIMEOUT) w = -1;
      do_instr(k, 8'($urandom), w, 8'($urandom));
    end
    @(negedge clk);
    clear_strobes();
    #1;
    chk_common("final", 1'b0, 1'b0, 1'b0, m_rdl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
